// File: rtl/gs_feeder_pkg.sv
// Shared constants and state encoding for the grayscale row feeder.
package gs_feeder_pkg;

    localparam int GS_WIDTH_DEF = 12;
    localparam int CHANNELS_DEF = 16;
    localparam int ROWS_DEF     = 8;
    localparam int LANES_DEF    = 12;
    localparam int BRIGHT_W     = 8;
    localparam int FRAME_W      = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        WAIT_ROW = 2'd2
    } gs_state_e;

endpackage

// File: rtl/gs_row_feeder_if.sv
// Frame-buffer read port and grayscale word stream between the feeder and its neighbours.
interface gs_row_feeder_if import gs_feeder_pkg::*; #(
    parameter int GS_WIDTH = GS_WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int LANES    = LANES_DEF
) ();

    localparam int ADDR_W = $clog2(ROWS * CHANNELS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int DATA_W = LANES * GS_WIDTH;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] gs_data;
    logic              gs_valid;
    logic              gs_ready;
    logic              gs_last;
    logic [ROW_W-1:0]  gs_row;

    modport master (
        output mem_addr, mem_rd, gs_data, gs_valid, gs_last, gs_row,
        input  mem_rdata, gs_ready
    );

    modport slave (
        input  mem_addr, mem_rd, gs_data, gs_valid, gs_last, gs_row,
        output mem_rdata, gs_ready
    );

endinterface

// File: rtl/gs_skid_buffer.sv
// Two-entry FIFO with a registered head; the head holds still while the consumer stalls.
module gs_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             push;
    logic             pop;

    assign out_valid_o = (count_q != 2'd0);
    assign in_ready_o  = (count_q != 2'd2);
    assign out_data_o  = head_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data_i;
                else                 tail_d = in_data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the incoming word goes behind whatever remains.
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end else begin
                    head_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gs_row_feeder.sv
// Fetches one row of grayscale words per XLAT, scales them by a per-frame brightness
// and streams them channel-high-first to the shift-register driver.
module gs_row_feeder import gs_feeder_pkg::*; #(
    parameter int GS_WIDTH = GS_WIDTH_DEF,
    parameter int CHANNELS = CHANNELS_DEF,
    parameter int ROWS     = ROWS_DEF,
    parameter int LANES    = LANES_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic                row_advance,
    output logic [FRAME_W-1:0]  frame_count,
    output logic                overrun,
    gs_row_feeder_if.master     bus
);

    localparam int DATA_W = LANES * GS_WIDTH;
    localparam int ADDR_W = $clog2(ROWS * CHANNELS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CH_W   = $clog2(CHANNELS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [CH_W-1:0]  CH_FIRST = CH_W'(CHANNELS - 1);

    gs_state_e           state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                done_q, done_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_last_q, rd_last_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;

    logic [DATA_W-1:0]   scaled;
    logic [DATA_W:0]     buf_out;
    logic                buf_valid;
    logic                buf_in_ready;
    logic                buf_last;
    logic [1:0]          buf_cnt;
    logic [2:0]          inflight;
    logic                pop;
    logic                space;
    logic                issue;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [GS_WIDTH+BRIGHT_W-1:0] prod;
            assign prod = {{BRIGHT_W{1'b0}}, bus.mem_rdata[gi*GS_WIDTH +: GS_WIDTH]}
                        * {{GS_WIDTH{1'b0}}, bright_q};
            assign scaled[gi*GS_WIDTH +: GS_WIDTH] = prod[GS_WIDTH+BRIGHT_W-1:BRIGHT_W];
        end
    endgenerate

    gs_skid_buffer #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .in_valid_i  (rd_vld_q),
        .in_ready_o  (buf_in_ready),
        .in_data_i   ({rd_last_q, scaled}),
        .out_valid_o (buf_valid),
        .out_ready_i (bus.gs_ready),
        .out_data_o  (buf_out)
    );

    assign buf_last = buf_out[DATA_W];
    assign pop      = buf_valid && bus.gs_ready;

    // Buffered words plus the one read still returning must never exceed two.
    assign buf_cnt  = !buf_valid ? 2'd0 : (buf_in_ready ? 2'd1 : 2'd2);
    assign inflight = {1'b0, buf_cnt} + {2'b00, rd_vld_q};
    assign space    = (inflight < 3'd2) || ((inflight == 3'd2) && pop);
    assign issue    = (state_q == FETCH) && !done_q && space;

    assign bus.mem_rd   = issue;
    assign bus.mem_addr = issue ? (ADDR_W'(row_q) * ADDR_W'(CHANNELS) + ADDR_W'(chan_q))
                                : '0;
    assign bus.gs_data  = buf_out[DATA_W-1:0];
    assign bus.gs_valid = buf_valid;
    assign bus.gs_last  = buf_valid && buf_last;
    assign bus.gs_row   = row_q;
    assign frame_count  = frame_q;
    assign overrun      = overrun_q;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        chan_d    = chan_q;
        done_d    = done_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        frame_d   = frame_q;
        bright_d  = bright_q;
        rd_vld_d  = issue;
        rd_last_d = issue && (chan_q == '0);

        if (issue) begin
            if (chan_q == '0) done_d = 1'b1;
            else              chan_d = chan_q - CH_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (row_advance) overrun_d = 1'b1;
                if (enable) begin
                    state_d = FETCH;
                    if (row_q == '0) bright_d = brightness;
                end
            end
            FETCH: begin
                if (row_advance) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (pop && buf_last) state_d = WAIT_ROW;
            end
            WAIT_ROW: begin
                if (row_advance || pending_q) begin
                    if (row_advance && pending_q) overrun_d = 1'b1;
                    pending_d = 1'b0;
                    chan_d    = CH_FIRST;
                    done_d    = 1'b0;
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        frame_d = frame_q + FRAME_W'(1);
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                    if (enable) begin
                        state_d = FETCH;
                        if (row_d == '0) bright_d = brightness;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            chan_q    <= CH_FIRST;
            done_q    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= '0;
            bright_q  <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            chan_q    <= chan_d;
            done_q    <= done_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
            bright_q  <= bright_d;
        end
    end

endmodule

// File: tb/tb_gs_row_feeder.sv
// Directed bench for gs_row_feeder: reset, scaling, backpressure, row sequencing, overrun.
module tb_gs_row_feeder;

    localparam int GSW = 12;
    localparam int CH  = 16;
    localparam int RW  = 8;
    localparam int LN  = 12;
    localparam int DW  = GSW * LN;
    localparam int AW  = 7;
    localparam logic [DW-1:0] ALL_7F8 = {LN{12'h7F8}};
    localparam logic [DW-1:0] ALL_7FF = {LN{12'h7FF}};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        row_advance = 1'b0;
    logic [7:0]  brightness = 8'd0;
    logic [15:0] frame_count;
    logic        overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hold_err = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    logic [AW-1:0] alog[$];
    logic [DW-1:0] xd[$];
    logic          xl[$];
    logic [2:0]    xr[$];
    int            xc[$];

    logic [DW-1:0] mem [RW*CH];

    gs_row_feeder_if #(.GS_WIDTH(GSW), .CHANNELS(CH), .ROWS(RW), .LANES(LN)) bus ();

    gs_row_feeder #(.GS_WIDTH(GSW), .CHANNELS(CH), .ROWS(RW), .LANES(LN)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .brightness  (brightness),
        .row_advance (row_advance),
        .frame_count (frame_count),
        .overrun     (overrun),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Transaction monitor, sampled mid-cycle.
    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(bus.gs_valid === 1'b1 && bus.gs_data === prev_data
                                && bus.gs_last === prev_last))
                hold_err++;
            if (bus.mem_rd) alog.push_back(bus.mem_addr);
            if (bus.gs_valid && bus.gs_ready) begin
                xd.push_back(bus.gs_data);
                xl.push_back(bus.gs_last);
                xr.push_back(bus.gs_row);
                xc.push_back(cyc);
                $display("xfer t=%0t row=%0d last=%0b data=%0h", $time, bus.gs_row, bus.gs_last, bus.gs_data);
            end
            prev_stall = bus.gs_valid && !bus.gs_ready;
            prev_data  = bus.gs_data;
            prev_last  = bus.gs_last;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse();
        row_advance = 1'b1;
        tick();
        row_advance = 1'b0;
    endtask

    task automatic clear();
        alog.delete();
        xd.delete();
        xl.delete();
        xr.delete();
        xc.delete();
    endtask

    task automatic wait_xfers(input int n, input bit rnd, input string tag);
        int k = 0;
        while (xd.size() < n && k < 600) begin
            if (rnd) bus.gs_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        bus.gs_ready = 1'b1;
        chk({tag, "_count"}, DW'(xd.size()), DW'(n));
    endtask

    function automatic logic [DW-1:0] exp_word(input int a, input int bri);
        logic [DW-1:0] w = mem[a];
        logic [DW-1:0] r = '0;
        for (int l = 0; l < LN; l++) begin
            int p = int'(w[l*GSW +: GSW]);
            r[l*GSW +: GSW] = GSW'((p * bri) >> 8);
        end
        return r;
    endfunction

    initial begin
        int k;
        for (int a = 0; a < RW*CH; a++)
            for (int l = 0; l < LN; l++)
                mem[a][l*GSW +: GSW] = (a < CH) ? 12'h800 : GSW'((a << 4) | l);
        bus.gs_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_gs_valid", DW'(bus.gs_valid), DW'(0));
        chk("rst_gs_last", DW'(bus.gs_last), DW'(0));
        chk("rst_gs_data", bus.gs_data, DW'(0));
        chk("rst_gs_row", DW'(bus.gs_row), DW'(0));
        chk("rst_mem_rd", DW'(bus.mem_rd), DW'(0));
        chk("rst_mem_addr", DW'(bus.mem_addr), DW'(0));
        chk("rst_frame_count", DW'(frame_count), DW'(0));
        chk("rst_overrun", DW'(overrun), DW'(0));

        // Row 0, full speed, brightness 255, pixel 0x800
        reset_n = 1'b1;
        enable = 1'b1;
        brightness = 8'd255;
        bus.gs_ready = 1'b1;
        clear();
        k = 0;
        while (!bus.gs_valid && k < 20) begin
            tick();
            k++;
        end
        chk("t2_first_valid_latency", DW'(k <= 3), DW'(1));
        wait_xfers(16, 1'b0, "t2");
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_data[%0d]", i), xd[i], ALL_7F8);
            chk($sformatf("t2_last[%0d]", i), DW'(xl[i]), DW'(i == 15));
            chk($sformatf("t2_addr[%0d]", i), DW'(alog[i]), DW'(15 - i));
        end
        chk("t2_throughput", DW'(xc[15] - xc[0]), DW'(15));

        // Row 1 with random backpressure
        clear();
        pulse();
        wait_xfers(16, 1'b1, "t3");
        repeat (4) tick();
        chk("t3_no_extra", DW'(xd.size()), DW'(16));
        chk("t3_addr_count", DW'(alog.size()), DW'(16));
        chk("t3_hold", DW'(hold_err), DW'(0));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_addr[%0d]", i), DW'(alog[i]), DW'(31 - i));
            chk($sformatf("t3_data[%0d]", i), xd[i], exp_word(31 - i, 255));
            chk($sformatf("t3_row[%0d]", i), DW'(xr[i]), DW'(1));
            chk($sformatf("t3_last[%0d]", i), DW'(xl[i]), DW'(i == 15));
        end

        // Rows 2..7, then wrap to row 0
        for (int r = 2; r < RW; r++) begin
            clear();
            pulse();
            wait_xfers(16, 1'b0, $sformatf("t4_row%0d", r));
            chk($sformatf("t4_first_row%0d", r), DW'(xr[0]), DW'(r));
            chk($sformatf("t4_final_row%0d", r), DW'(xr[15]), DW'(r));
            chk($sformatf("t4_frame_row%0d", r), DW'(frame_count), DW'(0));
        end
        clear();
        pulse();
        wait_xfers(1, 1'b0, "t4_wrap_first");
        enable = 1'b0;
        wait_xfers(16, 1'b0, "t4_wrap");
        chk("t4_wrap_row", DW'(xr[0]), DW'(0));
        chk("t4_wrap_data", xd[0], ALL_7F8);
        chk("t4_wrap_last", DW'(xl[15]), DW'(1));
        chk("t4_frame_count", DW'(frame_count), DW'(1));
        clear();
        pulse();
        repeat (3) tick();
        chk("t4_idle_valid", DW'(bus.gs_valid), DW'(0));
        chk("t4_idle_reads", DW'(alog.size()), DW'(0));
        chk("t4_idle_row", DW'(bus.gs_row), DW'(1));
        chk("t4_idle_overrun", DW'(overrun), DW'(0));

        // Overrun: two pulses during one stalled fetch
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        enable = 1'b1;
        bus.gs_ready = 1'b0;
        clear();
        repeat (4) tick();
        chk("t5_stall_valid", DW'(bus.gs_valid), DW'(1));
        chk("t5_stall_data", bus.gs_data, ALL_7F8);
        chk("t5_reads_bounded", DW'(alog.size()), DW'(2));
        pulse();
        chk("t5_one_pulse", DW'(overrun), DW'(0));
        pulse();
        chk("t5_two_pulses", DW'(overrun), DW'(1));
        bus.gs_ready = 1'b1;
        wait_xfers(16, 1'b0, "t5_row0");
        wait_xfers(32, 1'b0, "t5_row1");
        chk("t5_pending_row", DW'(xr[16]), DW'(1));
        pulse();
        wait_xfers(48, 1'b0, "t5_row2");
        pulse();
        wait_xfers(55, 1'b0, "t5_row3");
        chk("t5_row3", DW'(xr[54]), DW'(3));
        chk("t5_overrun_sticky", DW'(overrun), DW'(1));

        // Reset mid-row 3
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", DW'(bus.gs_valid), DW'(0));
        chk("t6_rst_mem_rd", DW'(bus.mem_rd), DW'(0));
        chk("t6_rst_data", bus.gs_data, DW'(0));
        chk("t6_rst_last", DW'(bus.gs_last), DW'(0));
        chk("t6_rst_overrun", DW'(overrun), DW'(0));
        chk("t6_rst_row", DW'(bus.gs_row), DW'(0));
        chk("t6_rst_frame", DW'(frame_count), DW'(0));

        // Brightness 0 on pixel 0xFFF
        for (int a = 0; a < CH; a++) mem[a] = {LN{12'hFFF}};
        brightness = 8'd0;
        tick();
        tick();
        reset_n = 1'b1;
        clear();
        wait_xfers(16, 1'b0, "t6");
        chk("t6_restart_row", DW'(xr[0]), DW'(0));
        chk("t6_restart_addr", DW'(alog[0]), DW'(15));
        chk("t6_last", DW'(xl[15]), DW'(1));
        for (int i = 0; i < 16; i++)
            chk($sformatf("t6_zero[%0d]", i), xd[i], DW'(0));

        // Brightness 128 latched at row start; later changes ignored
        reset_n = 1'b0;
        brightness = 8'd128;
        tick();
        reset_n = 1'b1;
        clear();
        tick();
        brightness = 8'd7;
        wait_xfers(16, 1'b0, "t7");
        for (int i = 0; i < 16; i++)
            chk($sformatf("t7_half[%0d]", i), xd[i], ALL_7FF);
        chk("t7_last", DW'(xl[15]), DW'(1));
        chk("final_hold", DW'(hold_err), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gs_row_feeder.md
GS_ROW_FEEDER -- requirements
Module: gs_row_feeder

Interface
REQ-001 SHALL have parameter GS_WIDTH, 12, grayscale bits per LED channel.
REQ-002 SHALL have parameter CHANNELS, 16, channels per driver chip, shifted per row.
REQ-003 SHALL have parameter ROWS, 8, multiplexed rows per panel.
REQ-004 SHALL have parameter LANES, 12, parallel serial lanes (6 left + 6 right).
REQ-005 SHALL have port clock, input, 1, the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, permits starting a new row fetch.
REQ-008 SHALL have port brightness, input, 8, global scale factor.
REQ-009 SHALL have port mem_addr, output, clog2(ROWS*CHANNELS), frame-buffer read address.
REQ-010 SHALL have port mem_rdata, input, LANES*GS_WIDTH, read data, valid exactly 1 cycle after mem_addr with mem_rd.
REQ-011 SHALL have port mem_rd, output, 1, read strobe.
REQ-012 SHALL have port gs_data, output, LANES*GS_WIDTH, scaled word for all lanes.
REQ-013 SHALL have port gs_valid, output, 1; gs_ready, input, 1; valid/ready handshake to the shifter.
REQ-014 SHALL have port gs_last, output, 1, marks the final word of a row.
REQ-015 SHALL have port gs_row, output, clog2(ROWS), row index of the current word.
REQ-016 SHALL have port row_advance, input, 1, single-cycle pulse from the driver when the row is latched (XLAT).
REQ-017 SHALL have port frame_count, output, 16; overrun, output, 1, sticky.

Function
REQ-018 SHALL implement states IDLE, FETCH, WAIT_ROW.
REQ-019 IDLE -> FETCH when enable=1; row counter unchanged.
REQ-020 FETCH SHALL issue reads for channel CHANNELS-1 down to 0 at mem_addr = row*CHANNELS + channel, one per cycle unless backpressured.
REQ-021 Transfer occurs only on gs_valid && gs_ready; gs_data SHALL hold stable while gs_valid=1 and gs_ready=0.
REQ-022 Each lane word SHALL equal (pixel * brightness) >> 8, truncated to GS_WIDTH; brightness latched at row-0 fetch start, so 0 gives all-zero, 255 gives pixel - ceil(pixel/256).
REQ-023 gs_last SHALL be 1 exactly on the channel-0 word; after its transfer, FETCH -> WAIT_ROW.
REQ-024 WAIT_ROW on row_advance (or a pending one): row increments, ROWS-1 wraps to 0 and frame_count increments (wraps at 2^16); then FETCH if enable=1, else IDLE.
REQ-025 row_advance during FETCH SHALL be held one-deep as pending; a second pulse while pending, or a pulse in IDLE, SHALL set overrun until reset.
REQ-026 Reads SHALL stall so that at most 2 words are in flight or buffered; no word is dropped or duplicated under any gs_ready pattern.
REQ-027 Ready-to-valid latency SHALL be at most 2 cycles from FETCH entry; steady-state throughput 1 word/cycle with gs_ready held 1.
REQ-028 enable deassertion SHALL not truncate a row in progress.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, row=0, channel=CHANNELS-1, pending=0.
REQ-030 During/after reset: gs_valid=0, gs_last=0, gs_data=0, gs_row=0, mem_rd=0, mem_addr=0, frame_count=0, overrun=0.
REQ-031 Reset assertion mid-row SHALL discard buffered words; the first row after release is row 0.

Structure
REQ-032 Package gs_feeder_pkg SHALL hold the state enum and default GS_WIDTH/CHANNELS/ROWS/LANES constants.
REQ-033 The 2-entry output buffer SHALL be sub-module gs_skid_buffer (width parameter, valid/ready both sides).

Verification
REQ-034 Reset, enable=1, gs_ready=1, brightness=255, pixel=0x800 -> first gs_valid within 2 cycles of FETCH, 16 words, gs_data lanes 0x7F8, gs_last on word 16.
REQ-035 gs_ready toggled pseudo-randomly over one row -> exactly 16 transfers, addresses 15..0 in order, data held while stalled.
REQ-036 8 rows with row_advance after each -> gs_row 0..7 then 0, frame_count=1.
REQ-037 Two row_advance pulses during one FETCH -> overrun=1, remains 1 until reset_n low.
REQ-038 reset_n low at word 7 of row 3 -> gs_valid=0 same cycle; after release rows restart at 0.
REQ-039 brightness=0, pixel=0xFFF -> all gs_data=0; brightness=128 -> 0x7FF.
